// File: rtl/replay_buffer.sv
// Replay buffer storage: holds sequence-tagged TLP words, purges on ACK, replays oldest-first on NAK/timeout.
// Optional replay counter with retrain pulse is enabled by defining REPLAY_NUM_EN.
module replay_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SEQ_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [DATA_W-1:0]        din,
    input  logic [1:0]               acknak,
    input  logic [SEQ_W-1:0]         ack_seq,
    input  logic                     to,
    input  logic                     dout_ready,
    output logic                     busy_n,
    output logic [DATA_W-1:0]        dout,
    output logic [SEQ_W-1:0]         dout_seq,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [SEQ_W-1:0]         wr_seq,
`ifdef REPLAY_NUM_EN
    output logic                     retrain,
`endif
    output logic                     err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {IDLE, REPLAY} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           rd_entry;
    state_t           state, state_nxt;
    logic [PW-1:0]    rd_ptr, wr_ptr, rp_ptr;
    logic [PW-1:0]    rd_ptr_nxt, wr_ptr_nxt, rp_ptr_nxt;
    logic [CW-1:0]    count_nxt, rp_cnt, rp_cnt_nxt, purge_amt;
    logic [SEQ_W-1:0] oldest_seq, oldest_seq_nxt, wr_seq_nxt, ack_n;
    logic             err_nxt, wr_ok;
    logic             is_ack, is_nak, purge_ok, purge_do, replay_start;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign is_ack       = (acknak == 2'b01);
    assign is_nak       = (acknak == 2'b10);
    assign ack_n        = ack_seq - oldest_seq + SEQ_W'(1);
    assign purge_ok     = (ack_n != '0) && (ack_n <= SEQ_W'(count));
    assign purge_do     = (state == IDLE) && (is_ack || is_nak) && purge_ok;
    assign purge_amt    = purge_do ? CW'(ack_n) : '0;
    assign replay_start = (state == IDLE) && (is_nak || to);

    // Replay output reads straight from storage; writes are blocked in REPLAY so it stays stable.
    assign rd_entry   = mem[rp_ptr];
    assign busy_n     = (state == REPLAY);
    assign dout_valid = busy_n && (rp_cnt != '0);
    assign dout       = dout_valid ? rd_entry.data : '0;
    assign dout_seq   = dout_valid ? rd_entry.seq  : '0;

    always_comb begin
        state_nxt      = state;
        rd_ptr_nxt     = rd_ptr;
        wr_ptr_nxt     = wr_ptr;
        rp_ptr_nxt     = rp_ptr;
        rp_cnt_nxt     = rp_cnt;
        count_nxt      = count;
        oldest_seq_nxt = oldest_seq;
        wr_seq_nxt     = wr_seq;
        err_nxt        = err;
        wr_ok          = 1'b0;
        case (state)
            IDLE: begin
                wr_ok = we && !full;
                if (we && full) err_nxt = 1'b1;
                count_nxt = count + CW'(wr_ok) - purge_amt;
                if (wr_ok) begin
                    wr_ptr_nxt = wr_ptr + PW'(1);
                    wr_seq_nxt = wr_seq + SEQ_W'(1);
                end
                if (purge_do) begin
                    rd_ptr_nxt     = rd_ptr + PW'(ack_n);
                    oldest_seq_nxt = oldest_seq + ack_n;
                end
                // A counter rather than pointer compare, so a full buffer still replays all entries.
                if (replay_start) begin
                    state_nxt  = REPLAY;
                    rp_ptr_nxt = rd_ptr_nxt;
                    rp_cnt_nxt = count_nxt;
                end
            end
            REPLAY: begin
                if (we) err_nxt = 1'b1;
                if (rp_cnt == '0) begin
                    state_nxt = IDLE;
                end else if (dout_ready) begin
                    rp_ptr_nxt = rp_ptr + PW'(1);
                    rp_cnt_nxt = rp_cnt - CW'(1);
                    if (rp_cnt == CW'(1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            rp_ptr     <= '0;
            rp_cnt     <= '0;
            count      <= '0;
            oldest_seq <= '0;
            wr_seq     <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rp_ptr     <= rp_ptr_nxt;
            rp_cnt     <= rp_cnt_nxt;
            count      <= count_nxt;
            oldest_seq <= oldest_seq_nxt;
            wr_seq     <= wr_seq_nxt;
            err        <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wr_ptr] <= '{data: din, seq: wr_seq};
    end

`ifdef REPLAY_NUM_EN
    logic [1:0] replay_num, replay_num_nxt, rn_base;
    logic       retrain_nxt;

    // A successful purge clears the count before a same-cycle NAK replay is counted.
    always_comb begin
        rn_base        = purge_do ? 2'd0 : replay_num;
        replay_num_nxt = rn_base;
        retrain_nxt    = 1'b0;
        if (replay_start) begin
            replay_num_nxt = rn_base + 2'd1;
            retrain_nxt    = (rn_base == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            replay_num <= '0;
            retrain    <= 1'b0;
        end else begin
            replay_num <= replay_num_nxt;
            retrain    <= retrain_nxt;
        end
    end
`endif

endmodule
